// File: rtl/icache_sa_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// Holds the refill FSM state encoding and the common hit/valid/zero constants.
package icache_sa_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icacheState_e;

    localparam logic        Hit       = 1'b1;
    localparam logic        Miss      = 1'b0;
    localparam logic        Valid     = 1'b1;
    localparam logic        Invalid   = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b1;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2Min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Word-read handshake between the instruction cache (master) and the memory controller (slave).
interface icache_sa_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_data_i
    );

endinterface

// File: rtl/icache_sa_way.sv
// One way of the instruction cache: valid bits, tags and line data for every set.
// Read side is combinational; fill, invalidate and flush-all are applied on the clock edge.
module icache_sa_way
    import icache_sa_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int TW         = 8,
    parameter int IW         = 6,
    parameter int OW         = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rdIdx_i,
    input  logic [OW-1:0] rdOff_i,
    input  logic [TW-1:0] rdTag_i,
    output logic          match_o,
    output logic          valid_o,
    output logic [31:0]   word_o,
    input  logic          wrEn_i,
    input  logic [IW-1:0] wrIdx_i,
    input  logic [OW-1:0] wrOff_i,
    input  logic [31:0]   wrData_i,
    input  logic [TW-1:0] wrTag_i,
    input  logic          fillDone_i,
    input  logic          inval_i,
    input  logic          flushAll_i
);

    localparam int AW = (LINE_WORDS > 1) ? IW + OW : IW;

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS*LINE_WORDS];
    logic [AW-1:0]   rdAddr;
    logic [AW-1:0]   wrAddr;

    if (LINE_WORDS > 1) begin : g_multiWord
        assign rdAddr = {rdIdx_i, rdOff_i};
        assign wrAddr = {wrIdx_i, wrOff_i};
    end else begin : g_singleWord
        assign rdAddr = rdIdx_i;
        assign wrAddr = wrIdx_i;
    end

    assign valid_o = valid_q[rdIdx_i];
    assign match_o = valid_q[rdIdx_i] && (tag_q[rdIdx_i] == rdTag_i);
    assign word_o  = data_q[rdAddr];

    // Flush-all beats a fill landing on the same edge, which is how a pending fence.i suppresses it.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else if (flushAll_i) begin
            valid_q <= '0;
        end else if (fillDone_i) begin
            valid_q[wrIdx_i] <= Valid;
        end else if (inval_i) begin
            valid_q[wrIdx_i] <= Invalid;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            data_q[wrAddr] <= wrData_i;
        end
        if (fillDone_i) begin
            tag_q[wrIdx_i] <= wrTag_i;
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with LRU replacement and a line-refill FSM.
// Define ICACHE_PERF_CNT_EN to add the perf_hit_o / perf_miss_o event counters.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush_i,
    input  logic        req_i,
    input  logic [31:0] pc_i,
    output logic        hit_o,
    output logic [31:0] inst_o,
    output logic        busy_o,
    icache_sa_if.master mem
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_o,
    output logic [31:0] perf_miss_o
`endif
);

    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int OW = clog2Min1(LINE_WORDS);
    localparam int IW = clog2Min1(SETS);
    localparam int TW = ADDR_W - 2 - OB - IB;
    localparam logic [31:0] BaseMask = 32'((64'd1 << ADDR_W) - 64'd1) & ~32'(LINE_WORDS * 4 - 1);

    icacheState_e    state_q, state_d;
    logic [OW-1:0]   cnt_q;
    logic [31:0]     base_q;
    logic [IW-1:0]   idx_q;
    logic [TW-1:0]   tag_q;
    logic            victim_q;
    logic            flushPend_q;
    logic [SETS-1:0] lru_q;

    logic [OW-1:0]   off;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic [WAYS-1:0] wayMatch;
    logic [WAYS-1:0] wayValid;
    logic [31:0]     wayWord [WAYS];
    logic            anyMatch, hitWay, victimSel, wayTarget, lastWord;
    logic            hitNow, missNow, ackNow;
    logic            dataWe, fillDone, inval, flushAll;
    logic [IW-1:0]   wrIdx;

    assign off = (LINE_WORDS > 1) ? pc_i[2 +: OW] : '0;
    assign idx = (SETS > 1) ? pc_i[2+OB +: IW] : '0;
    assign tag = pc_i[2+OB+IB +: TW];

    assign anyMatch = |wayMatch;
    assign hitWay   = (WAYS > 1) && wayMatch[WAYS-1];
    assign lastWord = (cnt_q == OW'(LINE_WORDS - 1));

    // Victim is the lowest invalid way; only when the set is full does LRU decide.
    assign victimSel = !wayValid[0]                     ? 1'b0 :
                       ((WAYS > 1) && !wayValid[WAYS-1]) ? 1'b1 :
                       ((WAYS > 1) && lru_q[idx]);
    assign wayTarget = (state_q == IDLE) ? victimSel : victim_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_sa_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TW(TW), .IW(IW), .OW(OW)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .rdIdx_i    (idx),
            .rdOff_i    (off),
            .rdTag_i    (tag),
            .match_o    (wayMatch[w]),
            .valid_o    (wayValid[w]),
            .word_o     (wayWord[w]),
            .wrEn_i     (dataWe && (wayTarget == 1'(w))),
            .wrIdx_i    (wrIdx),
            .wrOff_i    (cnt_q),
            .wrData_i   (mem.mem_data_i),
            .wrTag_i    (tag_q),
            .fillDone_i (fillDone && (wayTarget == 1'(w))),
            .inval_i    (inval && (wayTarget == 1'(w))),
            .flushAll_i (flushAll)
        );
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i && !flush_i && !anyMatch) state_d = REFILL;
            REFILL:  if (mem.mem_ack_i && lastWord) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hitNow   = rdy && (state_q == IDLE) && req_i && !flush_i && anyMatch;
        missNow  = rdy && (state_q == IDLE) && req_i && !flush_i && !anyMatch;
        ackNow   = rdy && (state_q == REFILL) && mem.mem_ack_i;
        hit_o    = hitNow ? Hit : Miss;
        inst_o   = hitNow ? wayWord[hitWay] : ZeroWord;
        busy_o   = (state_q == REFILL);
        mem.mem_req_o  = (state_q == REFILL);
        mem.mem_addr_o = (state_q == REFILL) ? base_q + (32'(cnt_q) << 2) : ZeroWord;
        dataWe   = ackNow;
        inval    = missNow;
        wrIdx    = (state_q == IDLE) ? idx : idx_q;
        fillDone = ackNow && lastWord && !(flushPend_q || flush_i);
        flushAll = (rdy && (state_q == IDLE) && flush_i) ||
                   (ackNow && lastWord && (flushPend_q || flush_i));
    end

    // Miss capture, word counter, pending flush and LRU; all frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q       <= '0;
            base_q      <= ZeroWord;
            idx_q       <= '0;
            tag_q       <= '0;
            victim_q    <= 1'b0;
            flushPend_q <= 1'b0;
            lru_q       <= '0;
        end else if (rdy) begin
            if (hitNow && (WAYS > 1)) begin
                lru_q[idx] <= ~hitWay;
            end
            if (missNow) begin
                base_q      <= pc_i & BaseMask;
                idx_q       <= idx;
                tag_q       <= tag;
                victim_q    <= victimSel;
                cnt_q       <= '0;
                flushPend_q <= 1'b0;
            end
            if (state_q == REFILL && flush_i) begin
                flushPend_q <= 1'b1;
            end
            if (ackNow) begin
                cnt_q <= cnt_q + 1'b1;
                if (lastWord) begin
                    flushPend_q <= 1'b0;
                    if (WAYS > 1) lru_q[idx_q] <= ~victim_q;
                end
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perfHit_q, perfMiss_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            perfHit_q  <= '0;
            perfMiss_q <= '0;
        end else begin
            if (hitNow)  perfHit_q  <= perfHit_q + 32'd1;
            if (missNow) perfMiss_q <= perfMiss_q + 32'd1;
        end
    end

    assign perf_hit_o  = perfHit_q;
    assign perf_miss_o = perfMiss_q;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: cold miss, 2-way conflict/LRU, flushes, rdy stall and reset mid-refill.
module tb_icache_sa;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush_i;
    logic        req_i;
    logic [31:0] pc_i;
    logic        hit_o;
    logic [31:0] inst_o;
    logic        busy_o;
    int          checks;
    int          errors;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_o;
    logic [31:0] perf_miss_o;
`endif

    icache_sa_if memBus ();

    icache_sa dut (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .flush_i (flush_i),
        .req_i   (req_i),
        .pc_i    (pc_i),
        .hit_o   (hit_o),
        .inst_o  (inst_o),
        .busy_o  (busy_o),
        .mem     (memBus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_o  (perf_hit_o),
        .perf_miss_o (perf_miss_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic flush);
        req_i   = req;
        pc_i    = pc;
        flush_i = flush;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic expHit, input logic [31:0] expInst);
        applyStimulus(1'b1, pc, 1'b0);
        #2;
        checkOutput($sformatf("hit@%h", pc), 32'(hit_o), 32'(expHit));
        checkOutput($sformatf("inst@%h", pc), inst_o, expInst);
    endtask

    task automatic refillWords(input logic [31:0] base, input logic [31:0] d0, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            #2;
            checkOutput($sformatf("memReq w%0d", i), 32'(memBus.mem_req_o), 32'd1);
            checkOutput($sformatf("memAddr w%0d", i), memBus.mem_addr_o, base + 32'(4 * i));
            checkOutput($sformatf("busy w%0d", i), 32'(busy_o), 32'd1);
            checkOutput($sformatf("hitInRefill w%0d", i), 32'(hit_o), 32'd0);
            memBus.mem_ack_i  = 1'b1;
            memBus.mem_data_i = d0 + 32'(i);
            tick();
            memBus.mem_ack_i  = 1'b0;
            memBus.mem_data_i = 32'h0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rdy = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        memBus.mem_ack_i  = 1'b0;
        memBus.mem_data_i = 32'h0;
        tick();
        tick();
        #2;
        checkOutput("rst hit", 32'(hit_o), 32'd0);
        checkOutput("rst inst", inst_o, 32'd0);
        checkOutput("rst busy", 32'(busy_o), 32'd0);
        checkOutput("rst memReq", 32'(memBus.mem_req_o), 32'd0);
        checkOutput("rst memAddr", memBus.mem_addr_o, 32'd0);
        rst = 1'b0;
        tick();

        // Cold miss on 0x100, refill, then zero-latency hits
        lookup(32'h100, 1'b0, 32'h0);
        checkOutput("missCycle busy", 32'(busy_o), 32'd0);
        tick();
        refillWords(32'h100, 32'hA0, 0, 3);
        checkOutput("afterFill memReq", 32'(memBus.mem_req_o), 32'd0);
        lookup(32'h108, 1'b1, 32'hA2);
        lookup(32'h10C, 1'b1, 32'hA3);
        tick();

        // Two-way conflict in set 0 with LRU eviction
        lookup(32'h000, 1'b0, 32'h0);
        tick();
        refillWords(32'h000, 32'hB0, 0, 3);
        lookup(32'h400, 1'b0, 32'h0);
        tick();
        refillWords(32'h400, 32'hC0, 0, 3);
        lookup(32'h000, 1'b1, 32'hB0);
        tick();
        lookup(32'h404, 1'b1, 32'hC1);
        tick();
        lookup(32'h004, 1'b1, 32'hB1);
        tick();
        lookup(32'h800, 1'b0, 32'h0);
        tick();
        refillWords(32'h800, 32'hD0, 0, 3);
        lookup(32'h000, 1'b1, 32'hB0);
        tick();
        lookup(32'h804, 1'b1, 32'hD1);
        lookup(32'h400, 1'b0, 32'h0);
        lookup(32'h104, 1'b1, 32'hA1);
        tick();

        // Flush in IDLE
        applyStimulus(1'b1, 32'h100, 1'b1);
        #2;
        checkOutput("flushCycle hit", 32'(hit_o), 32'd0);
        tick();
        lookup(32'h100, 1'b0, 32'h0);
        tick();
        #2;
        checkOutput("postFlush memReq", 32'(memBus.mem_req_o), 32'd1);

        // Flush mid-refill: refill completes but the line stays invalid
        refillWords(32'h100, 32'h30, 0, 1);
        applyStimulus(1'b1, 32'h100, 1'b1);
        #2;
        checkOutput("midFlush busy", 32'(busy_o), 32'd1);
        tick();
        applyStimulus(1'b1, 32'h100, 1'b0);
        refillWords(32'h100, 32'h30, 2, 3);
        #2;
        checkOutput("midFlush memReqDrop", 32'(memBus.mem_req_o), 32'd0);
        checkOutput("midFlush busyDrop", 32'(busy_o), 32'd0);
        lookup(32'h000, 1'b0, 32'h0);
        lookup(32'h100, 1'b0, 32'h0);
        tick();
        refillWords(32'h100, 32'hE0, 0, 3);
        lookup(32'h104, 1'b1, 32'hE1);
        tick();

        // rdy low for 3 cycles mid-refill with ack held high
        lookup(32'h200, 1'b0, 32'h0);
        tick();
        refillWords(32'h200, 32'hF0, 0, 0);
        rdy = 1'b0;
        memBus.mem_ack_i  = 1'b1;
        memBus.mem_data_i = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput($sformatf("stall memAddr %0d", i), memBus.mem_addr_o, 32'h204);
            checkOutput($sformatf("stall memReq %0d", i), 32'(memBus.mem_req_o), 32'd1);
            tick();
        end
        rdy = 1'b1;
        memBus.mem_ack_i  = 1'b0;
        memBus.mem_data_i = 32'h0;
        refillWords(32'h200, 32'hF0, 1, 3);
        lookup(32'h204, 1'b1, 32'hF1);
        lookup(32'h20C, 1'b1, 32'hF3);
        rdy = 1'b0;
        #2;
        checkOutput("rdyLow hit", 32'(hit_o), 32'd0);
        checkOutput("rdyLow inst", inst_o, 32'd0);
        rdy = 1'b1;
        tick();

        // Reset mid-refill
        lookup(32'h300, 1'b0, 32'h0);
        tick();
        refillWords(32'h300, 32'h10, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checkOutput("rstMid memReq", 32'(memBus.mem_req_o), 32'd0);
        checkOutput("rstMid busy", 32'(busy_o), 32'd0);
        lookup(32'h104, 1'b0, 32'h0);
        lookup(32'h000, 1'b0, 32'h0);
        lookup(32'h204, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();

        // One miss followed by five hits
        lookup(32'h040, 1'b0, 32'h0);
        tick();
        refillWords(32'h040, 32'h20, 0, 3);
        for (int i = 0; i < 5; i++) begin
            lookup(32'h040 + 32'(4 * (i % 4)), 1'b1, 32'h20 + 32'(i % 4));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        tick();
`ifdef ICACHE_PERF_CNT_EN
        checkOutput("perfMiss", perf_miss_o, 32'd1);
        checkOutput("perfHit", perf_hit_o, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache with multi-word lines and a refill state machine.
- Sits between the IF stage and the memory controller.
- Successor to the single-word direct-mapped icache: adds associativity with LRU replacement, line refill with its own memory handshake, and flush (fence.i) support.
- Lookup is combinational in IDLE; a miss stalls until the whole line is refilled.

Parameters:
- ADDR_W, 18, significant PC bits; bits above ADDR_W-1 are ignored.
- WAYS, 2, associativity; legal values are 1 and 2.
- SETS, 64, number of sets; must be a power of 2.
- LINE_WORDS, 4, 32-bit words per line; must be a power of 2 and at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when 0 the block freezes
- flush_i  in  1  invalidate all lines (fence.i)
- req_i  in  1  IF fetch request
- pc_i  in  32  fetch address; bits [1:0] ignored
- hit_o  out  1  inst_o is valid for pc_i this cycle
- inst_o  out  32  instruction; 0 when hit_o=0
- busy_o  out  1  refill in progress
- mem_req_o  out  1  word read request to the memory controller
- mem_addr_o  out  32  word-aligned address; upper bits are 0
- mem_ack_i  in  1  requested word is on mem_data_i
- mem_data_i  in  32  returned word

Behaviour:
- Address split:
  - off = pc[2+OB-1:2], where OB = log2(LINE_WORDS).
  - idx = next log2(SETS) bits.
  - tag = remaining bits up to ADDR_W-1.
- Storage per way: valid[SETS], tag[SETS], data[SETS*LINE_WORDS]. One lru bit per set, used only when WAYS=2; the bit names the least-recently-used way.
- Reset:
  - All valid bits and lru bits are 0; state = IDLE; word counter = 0.
  - hit_o=0, inst_o=0, busy_o=0, mem_req_o=0, mem_addr_o=0.
  - A reset during REFILL drops mem_req_o on the next edge; the partial line is discarded.
- rdy=0: no state, array or counter updates; hit_o=0 and inst_o=0; mem_req_o and mem_addr_o hold their values; mem_ack_i is ignored.
- IDLE, hit:
  - Condition: req_i=1, rdy=1, flush_i=0, and some way has valid[idx]=1 and tag match.
  - Same cycle: hit_o=1 and inst_o = data[way][idx][off]; zero-cycle latency.
  - Next edge: lru[idx] is set to the other way.
- IDLE, miss (req_i=1, no match):
  - Latch the line base (pc with off and [1:0] zeroed).
  - Choose the victim: the lowest invalid way, else lru[idx].
  - Clear valid[victim][idx]; reset the counter to 0; go to REFILL.
  - hit_o=0 during the miss cycle.
- REFILL:
  - busy_o=1; mem_req_o=1; mem_addr_o = base + 4*cnt.
  - On mem_ack_i=1: write mem_data_i into data[victim][idx][cnt] and increment cnt.
  - On the ack with cnt = LINE_WORDS-1:
    - write tag[victim][idx] and set valid[victim][idx]=1;
    - set lru[idx] so the filled way becomes MRU;
    - drop mem_req_o; go to IDLE.
  - The replayed request hits on the following cycle.
  - A refill costs LINE_WORDS acks plus 1 cycle before the hit.
  - hit_o=0 throughout REFILL, regardless of req_i or pc_i changes.
- Handshake:
  - mem_addr_o is stable while mem_req_o=1 until the ack.
  - One ack per word; the next word's address appears the cycle after the ack.
  - An ack arriving while mem_req_o=0 is ignored.
- Flush:
  - In IDLE: all valid bits clear on the next edge; hit_o=0 in the flush cycle; lru bits are unchanged.
  - During REFILL: the flush is recorded pending. The refill runs to completion because the memory cannot be cancelled, but the final valid set is suppressed and all valid bits are cleared on that edge.
  - flush_i together with rst: reset wins.
- Write-hit forwarding is not needed; the cache is read-only from the CPU side.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hit_o[31:0] and perf_miss_o[31:0].
  - Hit counter increments on each cycle with hit_o=1; miss counter increments on each IDLE to REFILL transition.
  - Both wrap at 2^32, clear on rst, and hold while rdy=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defines file:
  - ICACHE state encodings: IDLE=1'b0, REFILL=1'b1.
  - Existing Hit/Miss, Valid/Invalid, ZeroWord and RstEnable constants are reused.
- Natural sub-module: icache_way, one tag/valid/data array per way.
  - It takes the read idx/off and a write port, and returns match and word.
  - icache_sa instantiates WAYS copies and owns the FSM and lru.

Test Plan:
- Cold miss: rst, then req pc=0x100 → hit_o=0, busy_o=1. mem_addr_o steps 0x100, 0x104, 0x108, 0x10C with one ack each, data 0xA0..0xA3. After the last ack, req pc=0x108 → hit_o=1, inst_o=0xA2. pc=0x10C → 0xA3 with 0-cycle latency.
- Conflict, 2-way:
  - Fill 0x000 (idx 0), then 0x400, the same idx with a different tag.
  - Access 0x000 → hit.
  - Fill 0x800 → evicts 0x400 (the LRU way).
  - Then 0x000 hits and 0x400 misses.
- Flush in IDLE: with cached lines, pulse flush_i for 1 cycle → hit_o=0 that cycle; next req to a previously cached pc misses (mem_req_o=1).
- Flush mid-refill: assert flush_i after the 2nd ack → remaining acks are still consumed and mem_req_o drops after the 4th. The same pc then misses again.
- rdy and reset:
  - Hold rdy=0 for 3 cycles mid-refill while mem_ack_i=1 → cnt is unchanged and mem_addr_o is stable; the refill resumes when rdy=1.
  - Assert rst mid-refill → mem_req_o=0 and busy_o=0 next cycle; all lookups miss.
- With ICACHE_PERF_CNT_EN: 1 miss then 5 hits → perf_miss_o=1, perf_hit_o=5.
